gf2_solver: RTL and testbench

//   Inverse of the LPN response multiplier: recovers secret vector x from N row equations
//   A[i]·x = y[i] over GF(2), with y[i] = o[i] ^ e[i] supplied by the caller.

---
 rtl/gf2_solver_if.sv | 39 +++
 rtl/gf2_solver.sv | 164 ++++++++++++++++
 tb/tb_gf2_solver.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gf2_solver_if.sv
// ---------------------------------------------------------------------------
// gf2_solver_if
//   Row-load handshake and result bus for the GF(2) linear solver.
//
//   master (caller) drives:
//     clear      synchronous abort back to row loading
//     row_valid  row_a/row_y hold a row this cycle
//     row_a      N coefficients, row_a[j] multiplies x[j]
//     row_y      right-hand side bit of the row
//   slave (solver) drives:
//     row_ready  solver takes a row this cycle
//     busy       elimination in progress or result being presented
//     done       one-cycle pulse, x/singular valid
//     singular   matrix had no full rank
//     x          recovered vector
// ---------------------------------------------------------------------------
interface gf2_solver_if #(
  parameter int N = 128
);
  logic         clear;
  logic         row_valid;
  logic         row_ready;
  logic [N-1:0] row_a;
  logic         row_y;
  logic         busy;
  logic         done;
  logic         singular;
  logic [N-1:0] x;

  modport master (
    output clear, row_valid, row_a, row_y,
    input  row_ready, busy, done, singular, x
  );

  modport slave (
    input  clear, row_valid, row_a, row_y,
    output row_ready, busy, done, singular, x
  );
endinterface

// File: rtl/gf2_solver.sv
// ---------------------------------------------------------------------------
// gf2_solver
//   Recovers x from N equations A[i]·x = y[i] over GF(2). Rows are loaded one
//   per cycle into an N x (N+1) register array (bit N of each row is y), then
//   Gauss-Jordan elimination runs in place: one PIVOT cycle (find + swap) and
//   one ELIM cycle (clear column in all other rows) per column.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; aborts everything
//     sif    gf2_solver_if.slave: row handshake, busy/done, singular, x
// ---------------------------------------------------------------------------
module gf2_solver #(
  parameter int N = 128
) (
  input  logic         clk,
  input  logic         reset,
  gf2_solver_if.slave  sif
);
  localparam int CW = $clog2(N + 1);  // row count / column counter width
  localparam int IW = $clog2(N);      // row index width

  typedef enum logic [1:0] {LOAD, PIVOT, ELIM, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [CW-1:0]   col_reg, col_next;
  logic [N-1:0]    x_reg;
  logic            sing_reg;

  logic [N:0]      row_reg  [N];
  logic [N:0]      row_next [N];
  logic [N-1:0]    x_next;

  logic [IW-1:0]   col_idx;
  logic [IW-1:0]   piv;
  logic            found;
  logic [N:0]      pivot_row;
  logic            load_we, swap_en, elim_en, fin_ok, fin_sing;

  assign col_idx   = col_reg[IW-1:0];
  assign pivot_row = row_reg[col_idx];

  // Lowest row index r >= col with a 1 in the current column. Scanning from
  // the top down lets the last hit (lowest index) win.
  always_comb begin
    piv   = '0;
    found = 1'b0;
    for (int r = N - 1; r >= 0; r--) begin
      if (r >= int'(col_reg) && row_reg[r][col_reg]) begin
        piv   = IW'(r);
        found = 1'b1;
      end
    end
  end

  // Per-row next value. Load, swap and eliminate are mutually exclusive
  // because each belongs to a different state.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    assign row_next[gi] =
        (load_we && cnt_reg == CW'(gi))   ? {sif.row_y, sif.row_a} :
        (swap_en && col_reg == CW'(gi))   ? row_reg[piv] :
        (swap_en && piv == IW'(gi))       ? row_reg[col_idx] :
        (elim_en && col_reg != CW'(gi) && row_reg[gi][col_reg])
                                          ? (row_reg[gi] ^ pivot_row) :
                                            row_reg[gi];
    // After the final ELIM the matrix is the identity, so the y column is x.
    assign x_next[gi] = row_next[gi][N];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= LOAD;
      cnt_reg   <= '0;
      col_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      col_reg   <= col_next;
    end
  end

  // Next-state logic; clear overrides every state and suppresses all updates.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    col_next   = col_reg;
    load_we    = 1'b0;
    swap_en    = 1'b0;
    elim_en    = 1'b0;
    fin_ok     = 1'b0;
    fin_sing   = 1'b0;
    if (sif.clear) begin
      state_next = LOAD;
      cnt_next   = '0;
      col_next   = '0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (sif.row_valid) begin
            load_we = 1'b1;
            if (cnt_reg == CW'(N - 1)) state_next = PIVOT;
            else                       cnt_next   = cnt_reg + 1'b1;
          end
        end
        PIVOT: begin
          if (found) begin
            swap_en    = 1'b1;
            state_next = ELIM;
          end else begin
            fin_sing   = 1'b1;
            state_next = DONE;
          end
        end
        ELIM: begin
          elim_en = 1'b1;
          if (col_reg == CW'(N - 1)) begin
            fin_ok     = 1'b1;
            state_next = DONE;
          end else begin
            col_next   = col_reg + 1'b1;
            state_next = PIVOT;
          end
        end
        DONE: begin
          state_next = LOAD;
          cnt_next   = '0;
          col_next   = '0;
        end
        default: state_next = LOAD;
      endcase
    end
  end

  // Matrix storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) row_reg[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) row_reg[i] <= row_next[i];
    end
  end

  // Results are captured on entry to DONE so they are valid alongside done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg    <= '0;
      sing_reg <= 1'b0;
    end else if (fin_ok) begin
      x_reg    <= x_next;
      sing_reg <= 1'b0;
    end else if (fin_sing) begin
      x_reg    <= '0;
      sing_reg <= 1'b1;
    end
  end

  assign sif.row_ready = (state_reg == LOAD);
  assign sif.busy      = (state_reg != LOAD);
  assign sif.done      = (state_reg == DONE);
  assign sif.singular  = sing_reg;
  assign sif.x         = x_reg;
endmodule

// File: tb/tb_gf2_solver.sv
// ---------------------------------------------------------------------------
// tb_gf2_solver
//   Scoreboard bench for gf2_solver at N=128 and N=8. Stimulus pushes the
//   expected x / singular / done cycle into a queue; a negedge monitor pops
//   and compares on every done pulse. Cycle labels: the interval after
//   rising edge k is cycle k; the last row presented in cycle T.
// ---------------------------------------------------------------------------
module tb_gf2_solver;
  localparam int N = 128;
  localparam int M = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gf2_solver_if #(.N(N)) bus ();
  gf2_solver_if #(.N(M)) bus8 ();

  gf2_solver #(.N(N)) dut (
    .clk   (clk),
    .reset (rst),
    .sif   (bus.slave)
  );

  gf2_solver #(.N(M)) dut8 (
    .clk   (clk),
    .reset (rst),
    .sif   (bus8.slave)
  );

  typedef struct {
    logic [N-1:0] x;
    logic         sing;
    int           cyc;
    int           tag;
  } exp_t;

  exp_t q128[$];
  exp_t q8[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [N-1:0] A  [N];
  logic [N-1:0] yv;
  logic [M-1:0] A8 [M];
  logic [M-1:0] y8;

  function automatic void chk(input string nm, input logic [N-1:0] got,
                              input logic [N-1:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, got, expv);
    end
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done === 1'b1) begin
      if (q128.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done_n128: got done=1 at cycle %0d required no pulse", cyc);
      end else begin
        e = q128.pop_front();
        $display("n128 run %0d: done cycle %0d x=%h singular=%b", e.tag, cyc, bus.x, bus.singular);
        chk($sformatf("x_n128_run%0d", e.tag), bus.x, e.x);
        chk($sformatf("singular_n128_run%0d", e.tag), N'(bus.singular), N'(e.sing));
        chk($sformatf("done_cycle_n128_run%0d", e.tag), N'(cyc), N'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus8.done === 1'b1) begin
      if (q8.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done_n8: got done=1 at cycle %0d required no pulse", cyc);
      end else begin
        e = q8.pop_front();
        $display("n8 run %0d: done cycle %0d x=%h singular=%b", e.tag, cyc, bus8.x, bus8.singular);
        chk($sformatf("x_n8_run%0d", e.tag), N'(bus8.x), e.x);
        chk($sformatf("singular_n8_run%0d", e.tag), N'(bus8.singular), N'(e.sing));
        chk($sformatf("done_cycle_n8_run%0d", e.tag), N'(cyc), N'(e.cyc));
      end
    end
  end

  // ---------------- helpers ----------------
  // Called at posedge+1; presents one row for one cycle after `gap` idle cycles.
  task automatic send128(input logic [N-1:0] a, input logic y, input int gap, output int t);
    bus.row_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.row_a     = a;
    bus.row_y     = y;
    bus.row_valid = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    bus.row_valid = 1'b0;
  endtask

  task automatic send8(input logic [M-1:0] a, input logic y, output int t);
    bus8.row_a     = a;
    bus8.row_y     = y;
    bus8.row_valid = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    bus8.row_valid = 1'b0;
  endtask

  task automatic load128(input int gapmax, output int t);
    for (int i = 0; i < N; i++)
      send128(A[i], yv[i], (gapmax > 0) ? int'($urandom_range(gapmax)) : 0, t);
  endtask

  task automatic load8(output int t);
    for (int i = 0; i < M; i++) send8(A8[i], y8[i], t);
  endtask

  task automatic set_identity();
    for (int i = 0; i < N; i++) begin
      A[i]    = '0;
      A[i][i] = 1'b1;
    end
  endtask

  // Random row operations on the identity keep the matrix invertible.
  task automatic gen_invertible();
    logic [N-1:0] tmp;
    set_identity();
    for (int k = 0; k < 600; k++) begin
      int i = int'($urandom_range(N - 1));
      int j = int'($urandom_range(N - 1));
      if (i != j) begin
        if (k % 7 == 0) begin
          tmp = A[i]; A[i] = A[j]; A[j] = tmp;
        end else begin
          A[i] = A[i] ^ A[j];
        end
      end
    end
  endtask

  // y = A·x ^ e ^ e (the known error cancels)
  task automatic make_y(input logic [N-1:0] xs);
    logic e;
    for (int i = 0; i < N; i++) begin
      e     = 1'($urandom_range(1));
      yv[i] = (^(A[i] & xs)) ^ e ^ e;
    end
  endtask

  // Column at which Gauss-Jordan finds no pivot, or N if A is invertible.
  function automatic int model_fail_col();
    logic [N-1:0] m [N];
    logic [N-1:0] tmp;
    int p;
    for (int i = 0; i < N; i++) m[i] = A[i];
    for (int c = 0; c < N; c++) begin
      p = -1;
      for (int r = N - 1; r >= c; r--) if (m[r][c]) p = r;
      if (p < 0) return c;
      tmp = m[p]; m[p] = m[c]; m[c] = tmp;
      for (int i = 0; i < N; i++) if (i != c && m[i][c]) m[i] = m[i] ^ m[c];
    end
    return N;
  endfunction

  function automatic logic [N-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push128(input logic [N-1:0] xe, input logic se, input int ce, input int tag);
    exp_t e;
    e.x = xe; e.sing = se; e.cyc = ce; e.tag = tag;
    q128.push_back(e);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((q128.size() != 0 || q8.size() != 0) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (q128.size() != 0 || q8.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d results outstanding required 0", q128.size() + q8.size());
      q128.delete();
      q8.delete();
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, c;
    logic [N-1:0] xs, pat, prev_x;
    exp_t e8;

    bus.clear = 1'b0;  bus.row_valid = 1'b0;  bus.row_a = '0;  bus.row_y = 1'b0;
    bus8.clear = 1'b0; bus8.row_valid = 1'b0; bus8.row_a = '0; bus8.row_y = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_row_ready", N'(bus.row_ready), N'(1'b1));
    chk("reset_busy",      N'(bus.busy),      N'(1'b0));
    chk("reset_done",      N'(bus.done),      N'(1'b0));
    chk("reset_singular",  N'(bus.singular),  N'(1'b0));
    chk("reset_x",         bus.x,             '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Run 1: identity, y = A5A5..A5
    set_identity();
    pat = {16{8'hA5}};
    yv  = pat;
    load128(0, t);
    push128(pat, 1'b0, t + 2 * N + 1, 1);
    chk("busy_after_load",      N'(bus.busy),      N'(1'b1));
    chk("row_ready_after_load", N'(bus.row_ready), N'(1'b0));
    drain(400);

    // Run 2: reverse identity, y[i] = i[0]; x[j] = (N-1-j)[0]
    for (int i = 0; i < N; i++) begin
      A[i] = '0;
      A[i][N - 1 - i] = 1'b1;
      yv[i] = 1'(i % 2);
    end
    for (int j = 0; j < N; j++) xs[j] = 1'((N - 1 - j) % 2);
    load128(0, t);
    push128(xs, 1'b0, t + 2 * N + 1, 2);
    drain(400);

    // Run 3: random invertible A, random x, row_valid gaps
    gen_invertible();
    xs = rand128();
    make_y(xs);
    load128(2, t);
    push128(xs, 1'b0, t + 2 * N + 1, 3);
    drain(400);

    // Run 4: rows 3 and 7 identical -> singular
    gen_invertible();
    A[7] = A[3];
    yv   = rand128();
    c    = model_fail_col();
    load128(0, t);
    push128('0, 1'b1, t + 2 * c + 2, 4);
    drain(400);

    // Run 5: reset asserted during ELIM of column 40, no result expected
    set_identity();
    yv = rand128();
    load128(0, t);
    while (cyc < t + 82) begin @(posedge clk); #1; end
    chk("busy_in_elim40", N'(bus.busy), N'(1'b1));
    #2 rst = 1'b1;
    #1;
    chk("midreset_row_ready", N'(bus.row_ready), N'(1'b1));
    chk("midreset_busy",      N'(bus.busy),      N'(1'b0));
    chk("midreset_done",      N'(bus.done),      N'(1'b0));
    chk("midreset_singular",  N'(bus.singular),  N'(1'b0));
    chk("midreset_x",         bus.x,             '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Run 6: identity with y = 1 -> x = 1
    set_identity();
    yv = N'(1);
    load128(0, t);
    push128(N'(1), 1'b0, t + 2 * N + 1, 6);
    drain(400);

    // Run 7: 50 rows, clear together with a row, then full reload
    prev_x = N'(1);
    for (int i = 0; i < 50; i++) send128(rand128(), 1'b1, 0, t);
    bus.row_a = rand128(); bus.row_y = 1'b1; bus.row_valid = 1'b1; bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.row_valid = 1'b0; bus.clear = 1'b0;
    chk("after_clear_row_ready", N'(bus.row_ready), N'(1'b1));
    chk("after_clear_busy",      N'(bus.busy),      N'(1'b0));
    chk("after_clear_x_held",    bus.x,             prev_x);
    chk("after_clear_singular",  N'(bus.singular),  N'(1'b0));
    gen_invertible();
    xs = rand128();
    make_y(xs);
    load128(0, t);
    push128(xs, 1'b0, t + 2 * N + 1, 7);
    drain(400);

    // N=8, run 8: identity with y = 0x3C
    for (int i = 0; i < M; i++) begin
      A8[i] = '0;
      A8[i][i] = 1'b1;
    end
    y8 = 8'h3C;
    load8(t);
    e8.x = N'(8'h3C); e8.sing = 1'b0; e8.cyc = t + 2 * M + 1; e8.tag = 8;
    q8.push_back(e8);
    drain(60);

    // N=8, run 9: 5 rows, clear, then lower-triangular reload with x = 0xB6
    for (int i = 0; i < 5; i++) send8(8'hFF, 1'b1, t);
    bus8.clear = 1'b1;
    @(posedge clk); #1;
    bus8.clear = 1'b0;
    chk("n8_after_clear_busy",   N'(bus8.busy), N'(1'b0));
    chk("n8_after_clear_x_held", N'(bus8.x),    N'(8'h3C));
    for (int i = 0; i < M; i++) begin
      A8[i] = 8'((16'd1 << (i + 1)) - 16'd1);
      y8[i] = ^(A8[i] & 8'hB6);
    end
    load8(t);
    e8.x = N'(8'hB6); e8.sing = 1'b0; e8.cyc = t + 2 * M + 1; e8.tag = 9;
    q8.push_back(e8);
    drain(60);

    // Idle window: any stray done pulse is reported by the monitors.
    repeat (20) @(posedge clk);
    #1;
    chk("idle_x_held", bus.x, xs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
